reset_pulse_seq: RTL and testbench



---
 rtl/reset_pulse_seq.sv | 166 ++++++++++++++++
 tb/tb_reset_pulse_seq.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_pulse_seq.sv
// Pseudo-POC reset sequencer: captures three edge-triggered requesters, arbitrates
// brk > pseudo > host, and drives one stretched PSEUDORES pulse followed by a recovery gap.
module reset_pulse_seq #(
  parameter int unsigned ASSERT_CYC  = 30,
  parameter int unsigned RECOVER_CYC = 60,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             CLK60MHZ,
  input  logic             pocrflclr,
  input  logic             seq_en,
  input  logic             req_host,
  input  logic             req_pseudo,
  input  logic             req_brk,
  input  logic             cnt_clr,
  output logic             PSEUDORES,
  output logic             busy,
  output logic [1:0]       grant_id,
  output logic             done,
  output logic [2:0]       pend,
  output logic [CNT_W-1:0] event_cnt,
  output logic             ovf_flag
);

  localparam int unsigned TMR_W = 8;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ASSERT  = 2'd1;
  localparam logic [1:0] S_RECOVER = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [TMR_W-1:0] ASSERT_LOAD  = TMR_W'(ASSERT_CYC - 1);
  localparam logic [TMR_W-1:0] RECOVER_LOAD = TMR_W'(RECOVER_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  logic [1:0]       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [2:0]       req_prev_q, req_prev_d;
  logic [2:0]       pend_q, pend_d;
  logic             pres_q, pres_d;
  logic             busy_q, busy_d;
  logic [1:0]       gid_q, gid_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] evcnt_q, evcnt_d;
  logic             ovf_q, ovf_d;

  logic [2:0] req_now;
  logic [2:0] req_rise;
  logic [2:0] grant_oh;
  logic [2:0] pend_kept;
  logic       merge;

  // Next-state, pending capture and status counters.
  always_comb begin
    req_now    = {req_brk, req_pseudo, req_host};
    req_rise   = req_now & ~req_prev_q;
    req_prev_d = req_now;
    state_d    = state_q;
    tmr_d      = tmr_q;
    pres_d     = pres_q;
    busy_d     = busy_q;
    gid_d      = gid_q;
    done_d     = 1'b0;
    evcnt_d    = evcnt_q;
    ovf_d      = ovf_q;
    grant_oh   = 3'b000;

    case (state_q)
      S_IDLE: begin
        if (seq_en && (pend_q != 3'b000)) begin
          state_d = S_ASSERT;
          tmr_d   = ASSERT_LOAD;
          pres_d  = 1'b1;
          busy_d  = 1'b1;
          if (pend_q[2]) begin
            grant_oh = 3'b100;
            gid_d    = 2'd3;
          end else if (pend_q[1]) begin
            grant_oh = 3'b010;
            gid_d    = 2'd2;
          end else begin
            grant_oh = 3'b001;
            gid_d    = 2'd1;
          end
        end
      end
      S_ASSERT: begin
        if (tmr_q == '0) begin
          state_d = S_RECOVER;
          tmr_d   = RECOVER_LOAD;
          pres_d  = 1'b0;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_RECOVER: begin
        if (tmr_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          if (evcnt_q != CNT_MAX) begin
            evcnt_d = evcnt_q + CNT_W'(1);
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        gid_d   = 2'd0;
      end
      default: begin
        state_d = S_IDLE;
        pres_d  = 1'b0;
        busy_d  = 1'b0;
        gid_d   = 2'd0;
      end
    endcase

    // The winner's bit is dropped before new edges merge, so a re-request in the grant cycle is not an overflow.
    pend_kept = pend_q & ~grant_oh;
    merge     = seq_en && ((req_rise & pend_kept) != 3'b000);
    pend_d    = seq_en ? (pend_kept | req_rise) : 3'b000;

    if (cnt_clr) begin
      evcnt_d = '0;
      ovf_d   = 1'b0;
    end else if (merge) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge CLK60MHZ or posedge pocrflclr) begin
    if (pocrflclr) begin
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      req_prev_q <= 3'b000;
      pend_q     <= 3'b000;
      pres_q     <= 1'b0;
      busy_q     <= 1'b0;
      gid_q      <= 2'd0;
      done_q     <= 1'b0;
      evcnt_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      req_prev_q <= req_prev_d;
      pend_q     <= pend_d;
      pres_q     <= pres_d;
      busy_q     <= busy_d;
      gid_q      <= gid_d;
      done_q     <= done_d;
      evcnt_q    <= evcnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign PSEUDORES = pres_q;
  assign busy      = busy_q;
  assign grant_id  = gid_q;
  assign done      = done_q;
  assign pend      = pend_q;
  assign event_cnt = evcnt_q;
  assign ovf_flag  = ovf_q;

endmodule

// File: tb/tb_reset_pulse_seq.sv
// Bench for reset_pulse_seq: timeline reference model plus a grant/done scoreboard,
// directed scenarios followed by randomized request traffic and counter saturation.
module tb_reset_pulse_seq;
  localparam int unsigned A   = 30;
  localparam int unsigned R   = 60;
  localparam int unsigned CW  = 8;
  localparam int          SEQ = A + R;
  localparam int          CMAX = (1 << CW) - 1;

  logic CLK60MHZ = 1'b0;
  logic pocrflclr = 1'b1;
  logic seq_en = 1'b0;
  logic req_host = 1'b0;
  logic req_pseudo = 1'b0;
  logic req_brk = 1'b0;
  logic cnt_clr = 1'b0;
  logic          PSEUDORES;
  logic          busy;
  logic [1:0]    grant_id;
  logic          done;
  logic [2:0]    pend;
  logic [CW-1:0] event_cnt;
  logic          ovf_flag;

  reset_pulse_seq #(.ASSERT_CYC(A), .RECOVER_CYC(R), .CNT_W(CW)) dut (
    .CLK60MHZ(CLK60MHZ), .pocrflclr(pocrflclr), .seq_en(seq_en),
    .req_host(req_host), .req_pseudo(req_pseudo), .req_brk(req_brk), .cnt_clr(cnt_clr),
    .PSEUDORES(PSEUDORES), .busy(busy), .grant_id(grant_id), .done(done),
    .pend(pend), .event_cnt(event_cnt), .ovf_flag(ovf_flag)
  );

  always #8 CLK60MHZ = ~CLK60MHZ;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_seen = 0;

  typedef struct {int id; int rise; int done_c;} txn_t;
  txn_t sb_q[$];

  // Reference model: pending set semantics and a sequence timeline anchored at the grant edge.
  logic [2:0] m_pend = 3'b000;
  logic [2:0] m_prev = 3'b000;
  int         m_cnt = 0;
  logic       m_ovf = 1'b0;
  bit         m_active = 1'b0;
  int         m_g = 0;
  int         m_id = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    logic [2:0] rq;
    logic [2:0] rise;
    bit merged;
    bit done_now;
    int w;
    @(posedge CLK60MHZ or posedge pocrflclr);
    if (pocrflclr) begin
      m_pend = 3'b000; m_prev = 3'b000; m_cnt = 0; m_ovf = 1'b0;
      m_active = 1'b0; m_g = 0; m_id = 0;
      sb_q.delete();
    end else begin
      cyc++;
      rq = {req_brk, req_pseudo, req_host};
      rise = rq & ~m_prev;
      m_prev = rq;
      merged = 1'b0;
      done_now = m_active && (cyc == m_g + SEQ);
      if (seq_en && (m_pend != 3'b000) && (!m_active || cyc >= m_g + SEQ + 2)) begin
        w = m_pend[2] ? 3 : (m_pend[1] ? 2 : 1);
        m_pend[w-1] = 1'b0;
        m_g = cyc;
        m_id = w;
        m_active = 1'b1;
        sb_q.push_back('{id: w, rise: cyc, done_c: cyc + SEQ});
      end
      if (!seq_en) m_pend = 3'b000;
      else begin
        for (int b = 0; b < 3; b++) begin
          if (rise[b]) begin
            if (m_pend[b]) merged = 1'b1;
            m_pend[b] = 1'b1;
          end
        end
      end
      if (cnt_clr) begin
        m_cnt = 0;
        m_ovf = 1'b0;
      end else begin
        if (done_now && m_cnt < CMAX) m_cnt++;
        if (merged) m_ovf = 1'b1;
      end
    end
  end

  // Monitor: per-cycle output comparison and scoreboard pop on every done pulse.
  initial begin
    int   mon_rise;
    int   mon_w;
    logic last_pres;
    bit   win;
    txn_t t;
    mon_rise = -1; mon_w = 0; last_pres = 1'b0;
    forever begin
      @(negedge CLK60MHZ);
      if (pocrflclr) begin
        mon_rise = -1; mon_w = 0; last_pres = 1'b0;
      end else begin
        win = m_active && (cyc >= m_g) && (cyc <= m_g + SEQ);
        chk("pseudores", PSEUDORES, m_active && (cyc >= m_g) && (cyc < m_g + A));
        chk("busy", busy, win);
        chk("grant_id", grant_id, win ? m_id : 0);
        chk("done", done, m_active && (cyc == m_g + SEQ));
        chk("pend", pend, m_pend);
        chk("event_cnt", event_cnt, m_cnt);
        chk("ovf_flag", ovf_flag, m_ovf);
        if (PSEUDORES && !last_pres) begin
          mon_rise = cyc;
          mon_w = 0;
        end
        if (PSEUDORES) mon_w++;
        last_pres = PSEUDORES;
        if (done) begin
          if (sb_q.size() == 0) chk("sb_unexpected_done", 1, 0);
          else begin
            t = sb_q.pop_front();
            chk("sb_grant_id", grant_id, t.id);
            chk("sb_rise_cycle", mon_rise, t.rise);
            chk("sb_pulse_width", mon_w, A);
            chk("sb_done_cycle", cyc, t.done_c);
            done_seen++;
          end
        end
      end
    end
  end

  task automatic wait_rise(output int c, input int bound, input string name);
    logic p;
    c = -1;
    p = PSEUDORES;
    for (int i = 0; i < bound; i++) begin
      @(negedge CLK60MHZ);
      if (PSEUDORES && !p) begin
        c = cyc;
        return;
      end
      p = PSEUDORES;
    end
    chk({name, "_timeout"}, 1, 0);
  endtask

  task automatic wait_done(output int c, input int bound, input string name);
    c = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge CLK60MHZ);
      if (done) begin
        c = cyc;
        return;
      end
    end
    chk({name, "_timeout"}, 1, 0);
  endtask

  task automatic wait_idle(input int bound, input string name);
    for (int i = 0; i < bound; i++) begin
      @(negedge CLK60MHZ);
      if (!busy && pend == 3'b000) return;
    end
    chk({name, "_timeout"}, 1, 0);
  endtask

  task automatic pulse_req(input logic [2:0] m);
    @(negedge CLK60MHZ);
    {req_brk, req_pseudo, req_host} = m;
    @(negedge CLK60MHZ);
    {req_brk, req_pseudo, req_host} = 3'b000;
  endtask

  initial begin
    int e0, r, d, hi, base, guard;
    repeat (3) @(negedge CLK60MHZ);
    chk("rst_pseudores", PSEUDORES, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_event_cnt", event_cnt, 0);
    #1 pocrflclr = 1'b0;
    seq_en = 1'b1;
    repeat (4) @(negedge CLK60MHZ);

    // Single host request: latency, pulse length and done timing.
    req_host = 1'b1;
    e0 = cyc + 1;
    wait_rise(r, 10, "t1_rise");
    chk("t1_latency", r, e0 + 1);
    req_host = 1'b0;
    wait_done(d, 200, "t1_done");
    chk("t1_done_cycle", d, e0 + 1 + SEQ);
    chk("t1_grant_at_done", grant_id, 1);
    chk("t1_event_cnt", event_cnt, 1);
    @(negedge CLK60MHZ);
    chk("t1_grant_after", grant_id, 0);

    // Three simultaneous requests: brk, pseudo, host back to back.
    @(negedge CLK60MHZ);
    {req_brk, req_pseudo, req_host} = 3'b111;
    e0 = cyc + 1;
    @(negedge CLK60MHZ);
    {req_brk, req_pseudo, req_host} = 3'b000;
    chk("t2_pend_all", pend, 3'b111);
    for (int k = 0; k < 3; k++) begin
      wait_rise(r, 200, "t2_rise");
      chk("t2_rise_cycle", r, e0 + 1 + k * (SEQ + 2));
      chk("t2_grant_order", grant_id, 3 - k);
    end
    wait_idle(400, "t2_idle");
    chk("t2_event_cnt", event_cnt, 4);
    chk("t2_ovf", ovf_flag, 0);

    // Merge: pseudo requested twice during a brk pulse.
    @(negedge CLK60MHZ);
    cnt_clr = 1'b1;
    @(negedge CLK60MHZ);
    cnt_clr = 1'b0;
    pulse_req(3'b100);
    wait_rise(r, 10, "t3_rise");
    pulse_req(3'b010);
    pulse_req(3'b010);
    @(negedge CLK60MHZ);
    chk("t3_pend", pend, 3'b010);
    chk("t3_ovf", ovf_flag, 1);
    wait_idle(400, "t3_idle");
    chk("t3_event_cnt", event_cnt, 2);

    // Disable during ASSERT with a host request pending.
    pulse_req(3'b001);
    wait_rise(r, 10, "t4_rise");
    pulse_req(3'b001);
    chk("t4_pend_before", pend, 3'b001);
    seq_en = 1'b0;
    @(negedge CLK60MHZ);
    chk("t4_pend_cleared", pend, 3'b000);
    pulse_req(3'b001);
    wait_done(d, 200, "t4_done");
    chk("t4_done_cycle", d, r + SEQ);
    hi = 0;
    repeat (120) begin
      @(negedge CLK60MHZ);
      if (PSEUDORES) hi++;
    end
    chk("t4_no_pulse", hi, 0);
    seq_en = 1'b1;
    repeat (3) @(negedge CLK60MHZ);
    chk("t4_idle_busy", busy, 0);
    chk("t4_idle_pend", pend, 0);

    // Asynchronous reset mid-ASSERT.
    pulse_req(3'b001);
    wait_rise(r, 10, "t5_rise");
    pulse_req(3'b100);
    repeat (16) @(negedge CLK60MHZ);
    chk("t5_pres_before", PSEUDORES, 1);
    @(posedge CLK60MHZ);
    #2 pocrflclr = 1'b1;
    #1;
    chk("t5_pseudores", PSEUDORES, 0);
    chk("t5_busy", busy, 0);
    chk("t5_grant_id", grant_id, 0);
    chk("t5_pend", pend, 0);
    chk("t5_event_cnt", event_cnt, 0);
    chk("t5_done", done, 0);
    @(negedge CLK60MHZ);
    #1 pocrflclr = 1'b0;
    repeat (150) @(negedge CLK60MHZ);

    // cnt_clr coinciding with the DONE increment.
    pulse_req(3'b001);
    wait_idle(200, "t6_first");
    chk("t6_event_cnt_pre", event_cnt, 1);
    pulse_req(3'b001);
    wait_rise(r, 10, "t6_rise");
    guard = 0;
    while (cyc < r + SEQ - 1 && guard < 200) begin
      @(negedge CLK60MHZ);
      guard++;
    end
    cnt_clr = 1'b1;
    @(negedge CLK60MHZ);
    cnt_clr = 1'b0;
    chk("t6_done", done, 1);
    chk("t6_event_cnt_clr", event_cnt, 0);

    // Randomized traffic.
    repeat (15000) begin
      @(negedge CLK60MHZ);
      if ($urandom_range(0, 39) == 0) req_host = ~req_host;
      if ($urandom_range(0, 39) == 0) req_pseudo = ~req_pseudo;
      if ($urandom_range(0, 39) == 0) req_brk = ~req_brk;
      if ($urandom_range(0, 299) == 0) seq_en = ~seq_en;
      cnt_clr = ($urandom_range(0, 499) == 0);
    end
    seq_en = 1'b1;
    cnt_clr = 1'b0;

    // Continuous requests until the event counter must have saturated.
    base = done_seen;
    guard = 0;
    while (done_seen < base + 260 && guard < 30000) begin
      @(negedge CLK60MHZ);
      req_host = ~req_host;
      if ($urandom_range(0, 15) == 0) req_pseudo = ~req_pseudo;
      guard++;
    end
    chk("sat_done_count_reached", (done_seen >= base + 260), 1);
    {req_brk, req_pseudo, req_host} = 3'b000;
    chk("sat_event_cnt", event_cnt, CMAX);
    wait_idle(400, "drain");
    chk("sb_queue_empty", sb_q.size(), 0);
    chk("sat_event_cnt_hold", event_cnt, CMAX);
    @(negedge CLK60MHZ);
    cnt_clr = 1'b1;
    @(negedge CLK60MHZ);
    cnt_clr = 1'b0;
    chk("final_event_cnt_clr", event_cnt, 0);
    chk("final_ovf_clr", ovf_flag, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
